// File: rtl/mips_div_pkg.sv
// Purpose: shared types and constants for the MIPS DIV/DIVU sequential divider.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package mips_div_pkg;

  localparam int          DIV_WIDTH     = 32;
  localparam int          DIV_CNT_W     = 5;
  localparam logic [31:0] DIV0_QUOTIENT = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_t;

  // Magnitude of an operand. In signed mode 32'h8000_0000 maps to itself,
  // which is exactly 2^31 when the result is read as unsigned.
  function automatic logic [31:0] div_abs(input logic [31:0] x, input logic sgn);
    return (sgn && x[31]) ? -x : x;
  endfunction

endpackage

// File: rtl/div_trial_sub33.sv
// Purpose: 33-bit trial subtractor (a - b as a + ~b + 1) built as a ripple of full-adder cells.
// Latency: combinational.
// Backpressure: none; pure function of its inputs.
// Ports: a, b (33b operands), diff (33b a-b modulo 2^33), nonneg (carry out, 1 when a >= b).
module div_trial_sub33 (
  input  logic [32:0] a,
  input  logic [32:0] b,
  output logic [32:0] diff,
  output logic        nonneg
);

  logic carry;
  logic bi;

  // Carry-in of 1 plus inverted b gives two's-complement subtraction;
  // the final carry is the "no borrow" indication.
  always_comb begin
    carry = 1'b1;
    bi    = 1'b0;
    diff  = '0;
    for (int i = 0; i < 33; i++) begin
      bi      = ~b[i];
      diff[i] = a[i] ^ bi ^ carry;
      carry   = (a[i] & bi) | (carry & (a[i] ^ bi));
    end
    nonneg = carry;
  end

endmodule

// File: rtl/seq_divider32.sv
// Purpose: multi-cycle radix-2 restoring divider for DIV/DIVU; quotient -> LO, remainder -> HI.
// Latency: done 34 cycles after an accepted start (1 cycle for a zero divisor); one op in flight.
// Backpressure: start is only taken in IDLE; the execute stage stalls while busy is high.
// Ports: clk, rst_n, start, is_signed, dividend, divisor in; busy, done, quotient, remainder, div_by_zero out.
module seq_divider32
  import mips_div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH,
  parameter int CNT_W = DIV_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  div_state_t       state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] q_reg;     // dividend magnitude shifting out, quotient bits shifting in
  logic [WIDTH-1:0] rem_reg;
  logic [WIDTH-1:0] dvsr_reg;
  logic             neg_q;
  logic             neg_r;

  logic [WIDTH:0]   trial_a;
  logic [WIDTH:0]   trial_diff;
  logic             trial_ok;
  logic             take_trial;

  // Partial remainder shifted left by one with the next dividend bit appended.
  assign trial_a = {rem_reg, q_reg[WIDTH-1]};

  div_trial_sub33 u_trial (
    .a      (trial_a),
    .b      ({1'b0, dvsr_reg}),
    .diff   (trial_diff),
    .nonneg (trial_ok)
  );

  // An accepted trial is always below the divisor, so its top bit is clear;
  // it is folded in as a guard so a corrupt difference can never be kept.
  assign take_trial = trial_ok & ~trial_diff[WIDTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: if (start) state_nxt = (divisor == '0) ? DONE : ITER;
      ITER: begin
        busy = 1'b1;
        if (cnt == '1) state_nxt = FIX;
      end
      FIX: begin
        busy      = 1'b1;
        state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      q_reg       <= '0;
      rem_reg     <= '0;
      dvsr_reg    <= '0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            div_by_zero <= (divisor == '0);
            if (divisor == '0) begin
              quotient  <= DIV0_QUOTIENT;
              remainder <= dividend;
            end else begin
              q_reg    <= div_abs(dividend, is_signed);
              dvsr_reg <= div_abs(divisor, is_signed);
              rem_reg  <= '0;
              cnt      <= '0;
              neg_q    <= is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
              neg_r    <= is_signed & dividend[WIDTH-1];
            end
          end
        end
        ITER: begin
          rem_reg <= take_trial ? trial_diff[WIDTH-1:0] : trial_a[WIDTH-1:0];
          q_reg   <= {q_reg[WIDTH-2:0], take_trial};
          cnt     <= cnt + 1'b1;
        end
        FIX: begin
          // Truncating division: quotient sign is the XOR of operand signs,
          // remainder follows the dividend.
          quotient  <= neg_q ? -q_reg : q_reg;
          remainder <= neg_r ? -rem_reg : rem_reg;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider32.sv
// Purpose: randomized + directed scoreboard bench for seq_divider32.
// Latency: checks 34-cycle (1-cycle for zero divisor) start-to-done timing.
// Backpressure: drives start only after done; also pokes start while busy to confirm it is ignored.
module tb_seq_divider32;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        is_signed = 1'b0;
  logic [31:0] dividend = '0;
  logic [31:0] divisor = '0;
  logic        busy, done, div_by_zero;
  logic [31:0] quotient, remainder;

  seq_divider32 dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .is_signed   (is_signed),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
    int          t0;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference: plain integer division with truncation toward zero.
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic s);
    exp_t   e;
    longint sa, sb_;
    e.t0 = 0;
    if (b == 0) begin
      e.q = 32'hFFFF_FFFF; e.r = a; e.dz = 1'b1; e.lat = 1;
    end else begin
      e.dz = 1'b0; e.lat = 34;
      if (s) begin
        sa   = longint'($signed(a));
        sb_  = longint'($signed(b));
        e.q  = 32'(sa / sb_);
        e.r  = 32'(sa % sb_);
      end else begin
        e.q = a / b;
        e.r = a % b;
      end
    end
    return e;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        n_cmp++; n_fail++;
        $display("FAIL unexpected_done: done=1 with no operation outstanding (t=%0t)", $time);
      end else begin
        e = sb.pop_front();
        chk("quotient", quotient, e.q);
        chk("remainder", remainder, e.r);
        chk("div_by_zero", 32'(div_by_zero), 32'(e.dz));
        chk("latency", 32'(cyc - e.t0), 32'(e.lat));
      end
    end
  end

  // Issue one operation and wait for its done. With inject set, start is
  // re-asserted with fresh operands while busy; it must have no effect.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s, input bit inject);
    exp_t e;
    int   busy_cnt;
    bit   got;
    busy_cnt = 0;
    got      = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; dividend = a; divisor = b; is_signed = s;
    e = model(a, b, s);
    e.t0 = cyc;
    sb.push_back(e);
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      dividend  = $urandom;
      divisor   = $urandom;
      is_signed = 1'($urandom_range(0, 1));
      start     = inject && busy && (i < 20);
      if (busy) busy_cnt++;
      if (done) begin got = 1'b1; break; end
    end
    start = 1'b0;
    chk("done_seen", 32'(got), 32'd1);
    chk("busy_cycles", 32'(busy_cnt), (b == 0) ? 32'd0 : 32'd33);
  endtask

  initial begin
    logic [31:0] a, b;
    int          sel;

    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_quotient", quotient, 32'd0);
    chk("rst_remainder", remainder, 32'd0);
    chk("rst_div_by_zero", 32'(div_by_zero), 32'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    run_op(32'd100, 32'd7, 1'b0, 1'b0);
    run_op(-32'sd7, 32'd2, 1'b1, 1'b0);
    run_op(32'd7, -32'sd2, 1'b1, 1'b0);
    run_op(32'd5, 32'd0, 1'b0, 1'b0);
    run_op(32'd5, 32'd0, 1'b1, 1'b0);
    run_op(32'd12, 32'd5, 1'b0, 1'b0);
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0);
    run_op(32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0);
    run_op(32'h8000_0000, 32'd3, 1'b1, 1'b0);
    run_op(32'd3, 32'd10, 1'b0, 1'b0);
    run_op(32'd1000, 32'd3, 1'b0, 1'b1);
    run_op(-32'sd1000, 32'd7, 1'b1, 1'b1);

    // Abort mid-iteration: outputs drop at once and the op never completes.
    @(posedge clk); #1;
    start = 1'b1; dividend = 32'd12345; divisor = 32'd77; is_signed = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_quotient", quotient, 32'd0);
    chk("abort_remainder", remainder, 32'd0);
    chk("abort_div_by_zero", 32'(div_by_zero), 32'd0);
    repeat (3) @(negedge clk);
    chk("abort_no_done", 32'(done), 32'd0);
    rst_n = 1'b1;
    run_op(32'd9, 32'd3, 1'b0, 1'b0);

    for (int n = 0; n < 150; n++) begin
      sel = $urandom_range(0, 9);
      a   = $urandom;
      b   = $urandom;
      case (sel)
        0: b = 32'd0;
        1: b = 32'd1;
        2: b = 32'hFFFF_FFFF;
        3: b = 32'($urandom_range(1, 15));
        4: a = 32'h8000_0000;
        5: a = 32'($urandom_range(0, 100));
        default: ;
      endcase
      run_op(a, b, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 7) == 0));
    end

    repeat (5) @(posedge clk);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
